// File: rtl/amber128_bundle_unpacker.sv
// Fetch-bundle unpacker: buffers one 128-bit bundle and issues its slots (or 12-bit half-slots)
// one per cycle to the decoder, refilling in the same cycle the last op is taken.
module amber128_bundle_unpacker #(
  parameter int unsigned SLOTS  = 5,
  parameter int unsigned SLOT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [63:0]       in_word_addr_i,
  input  logic [127:0]      in_bundle_i,
  input  logic [2:0]        in_start_slot_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [63:0]       out_word_addr_o,
  output logic [2:0]        out_slot_idx_o,
  output logic              out_sub12_idx_o,
  output logic              out_is12_o,
  output logic [SLOT_W-1:0] out_payload_o,
  output logic              out_last_o
);

  localparam int unsigned HalfW   = SLOT_W / 2;
  localparam int unsigned FlagLsb = 128 - SLOTS;
  localparam logic [2:0]  LastSlot = 3'(SLOTS - 1);
  localparam logic [2:0]  NumSlots = 3'(SLOTS);

  typedef enum logic [0:0] {StEmpty, StActive} state_e;

  state_e       state_q, state_d;
  logic [127:0] bundle_q, bundle_d;
  logic [63:0]  addr_q, addr_d;
  logic [2:0]   slot_q, slot_d;
  logic         sub_q, sub_d;

  logic [SLOT_W-1:0] slot_data;
  logic              pair_flag;
  logic              fire;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      bundle_q <= '0;
      addr_q   <= '0;
      slot_q   <= '0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      addr_q   <= addr_d;
      slot_q   <= slot_d;
      sub_q    <= sub_d;
    end
  end

  // Select the current slot from the buffered bundle; out-of-range cursor reads as zero.
  always_comb begin
    slot_data = '0;
    pair_flag = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q == 3'(i)) begin
        slot_data = bundle_q[i*SLOT_W +: SLOT_W];
        pair_flag = bundle_q[FlagLsb + i];
      end
    end
  end

  assign fire   = out_valid_o && out_ready_i;
  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    addr_d   = addr_q;
    slot_d   = slot_q;
    sub_d    = sub_q;
    if (flush_i) begin
      state_d = StEmpty;
      slot_d  = '0;
      sub_d   = 1'b0;
    end else if (accept) begin
      bundle_d = in_bundle_i;
      addr_d   = in_word_addr_i;
      sub_d    = 1'b0;
      // A start slot past the end leaves nothing to issue.
      if (in_start_slot_i < NumSlots) begin
        state_d = StActive;
        slot_d  = in_start_slot_i;
      end else begin
        state_d = StEmpty;
        slot_d  = '0;
      end
    end else if (fire) begin
      if (out_last_o) begin
        state_d = StEmpty;
      end else if (pair_flag && !sub_q) begin
        sub_d = 1'b1;
      end else begin
        slot_d = slot_q + 3'd1;
        sub_d  = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_o     = (state_q == StActive);
    out_word_addr_o = addr_q;
    out_slot_idx_o  = slot_q;
    out_sub12_idx_o = sub_q;
    out_is12_o      = pair_flag;
    out_last_o      = (slot_q == LastSlot) && (!pair_flag || sub_q);
    if (pair_flag) begin
      out_payload_o = {{HalfW{1'b0}}, sub_q ? slot_data[SLOT_W-1:HalfW] : slot_data[HalfW-1:0]};
    end else begin
      out_payload_o = slot_data;
    end
    in_ready_o = !flush_i && ((state_q == StEmpty) || (fire && out_last_o));
  end

endmodule

// File: doc/amber128_bundle_unpacker.md
# amber128_bundle_unpacker

Sits between IMEM fetch and the decoder: accepts one 128-bit fetch bundle at a time (`amber128_fetch_s` layout) and emits its instructions one per cycle over a valid/ready handshake. Splits 12-bit pair slots into two sub-ops and tags each op with bundle address, slot index and sub-index for the decoder to populate `amber128_decode_s`. Single-bundle buffer with same-cycle refill, so sustained throughput is one op per cycle with no inter-bundle bubble.

## Interface
- `SLOTS`, 5: slots per bundle; fixed by the bundle format.
- `SLOT_W`, 24: slot payload width; 12-bit sub-ops are `SLOT_W/2`.
- `clk  in  1  clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `flush_i  in  1  synchronous flush (branch redirect/trap); highest priority`
- `in_valid_i  in  1  fetch bundle valid (`amber128_fetch_s.valid`)`
- `in_ready_o  out  1  unpacker can take a bundle this cycle`
- `in_word_addr_i  in  64  16-byte-aligned bundle byte address`
- `in_bundle_i  in  128  [127:123] pair flags, slot i flag = bit 123+i; [119:0] slot i = bits [24i+23:24i]; [122:120] ignored`
- `in_start_slot_i  in  3  first slot to issue (branch target inside bundle)`
- `out_valid_o  out  1  op valid`
- `out_ready_i  in  1  decoder accepts op`
- `out_word_addr_o  out  64  bundle address of op`
- `out_slot_idx_o  out  3  0..4`
- `out_sub12_idx_o  out  1  0 = low half/24-bit op, 1 = high half`
- `out_is12_o  out  1  op is a 12-bit form`
- `out_payload_o  out  24  24-bit op, or 12-bit op zero-extended`
- `out_last_o  out  1  op is last of its bundle`

## Operation
- State: `EMPTY` / `ACTIVE`; registers: bundle (128), address (64), cursor {slot[2:0], sub}.
- Accept (`in_valid_i && in_ready_o && !flush_i`): latch bundle, address; cursor = {in_start_slot_i, 0}; go `ACTIVE`.
- `in_start_slot_i >= 5`: bundle accepted and discarded; state stays/returns `EMPTY`, no op emitted.
- Issue order: ascending slot; within pair slot, sub 0 = bits [11:0] then sub 1 = bits [23:12]; non-pair slot emits one op, sub 0, `out_is12_o`=0.
- Advance on `out_valid_o && out_ready_i`: pair slot sub 0 -> sub 1; else slot+1, sub 0.
- `out_last_o` = 1 when slot = 4 and (non-pair or sub = 1).
- `in_ready_o` = `EMPTY` or (`out_valid_o && out_ready_i && out_last_o`); on last-op handshake with accept, new bundle loads, stays `ACTIVE`; without accept, go `EMPTY`.
- `flush_i`: next cycle `EMPTY`, cursor 0; any concurrent in_valid ignored (`in_ready_o` forced 0 while flush_i high); op handshaking in flush cycle counts as consumed by decoder but is discarded downstream.
- Ops per bundle: (5 - start) + number of pair flags in slots >= start; range 1..10.

## Timing
- Reset: state `EMPTY`, all buffers/cursor 0; `out_valid_o`=0, `in_ready_o`=1, all other outputs 0.
- All `out_*` driven only from registers (no combinational path from `in_*`); `in_ready_o` combinational from state, `out_ready_i`, `flush_i`.
- Bundle accepted cycle N -> first op valid cycle N+1.
- Back-to-back: last op handshake and next bundle accept same cycle N -> new bundle's first op cycle N+1.
- `out_ready_i`=0 holds all `out_*` stable; `out_valid_o` never drops without handshake or flush.
- Reset asserted mid-bundle: immediate return to reset values; remaining ops lost.

## Test plan
- All flags 0, slots 0xA00001..0xA00005, start 0, ready=1 -> 5 ops cycles N+1..N+5, payloads in order, slot_idx 0..4, is12=0, last only on slot 4.
- Flags 0b00101 (slots 0, 2 pairs), slot0=0x456123 -> ops 0x000123 (sub0), 0x000456 (sub1), …; 7 ops total, is12=1 only on slots 0, 2.
- start=3, flags 0b10000 -> 3 ops: slot 3, slot 4 sub0, slot 4 sub1 (last); start=5 -> zero ops, in_ready stays 1.
- Two bundles presented back-to-back, ready=1 -> 10 consecutive valid cycles, no bubble, word_addr switches from 0x100 to 0x110 at op 6.
- out_ready toggled 1,0,0,1 -> outputs held during stall cycles; no op dropped or duplicated.
- flush_i at op 2 with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle; new bundle after flush emits from its start slot.
